// File: rtl/mult_arbiter.sv
// mult_arbiter
// Shares one multiplier among NUM_REQ requesters. A round-robin pick in IDLE
// accepts one request, latches its operands, pulses m_start for one cycle,
// waits for m_done (guarded by a watchdog) and returns the product to the
// owner. Operations never overlap.
//
// Ports
//   clock, reset             sole rising-edge clock, async active-high reset
//   req_valid / req_ready    per-requester request handshake (ready is combinational)
//   req_mcand / req_mplier   per-requester operands, slice i = [64*i+63:64*i]
//   rsp_valid / rsp_ready    per-requester response handshake
//   rsp_product, rsp_err     shared result bus; rsp_err flags a watchdog abort
//   m_start, m_mcand,
//   m_mplier                 command to the multiplier
//   m_product, m_done        result from the multiplier
//   busy, grant_id           arbiter not in IDLE / index of current owner
module mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*64-1:0] req_mcand,
  input  logic [NUM_REQ*64-1:0] req_mplier,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic [63:0]          rsp_product,
  output logic                 rsp_err,
  output logic                 m_start,
  output logic [63:0]          m_mcand,
  output logic [63:0]          m_mplier,
  input  logic [63:0]          m_product,
  input  logic                 m_done,
  output logic                 busy,
  output logic [2:0]           grant_id
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [3:0]  NUM_REQ_W = 4'(NUM_REQ);
  localparam logic [2:0]  LAST_REQ  = 3'(NUM_REQ - 1);
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  state_e      state_q, state_d;
  logic [2:0]  rr_q, rr_d;
  logic [2:0]  grant_q, grant_d;
  logic [63:0] mcand_q, mcand_d;
  logic [63:0] mplier_q, mplier_d;
  logic [15:0] wd_q, wd_d;
  logic [63:0] prod_q, prod_d;
  logic        err_q, err_d;
  logic        m_start_q, m_start_d;
  logic        busy_q, busy_d;

  // Requester vectors widened to 8 so a 3-bit index never runs off the end.
  logic [7:0]  valid_pad_s;
  logic [7:0]  rsp_ready_pad_s;
  logic [63:0] mcand_arr_s  [8];
  logic [63:0] mplier_arr_s [8];

  logic [3:0]  search_sum_s;
  logic [2:0]  search_idx_s;
  logic        win_found_s;
  logic [2:0]  win_idx_s;
  logic        accept_s;
  logic [15:0] wd_inc_s;

  assign valid_pad_s     = 8'(req_valid);
  assign rsp_ready_pad_s = 8'(rsp_ready);

  for (genvar g = 0; g < 8; g++) begin : g_ops
    if (g < NUM_REQ) begin : g_live
      assign mcand_arr_s[g]  = req_mcand[64*g +: 64];
      assign mplier_arr_s[g] = req_mplier[64*g +: 64];
    end else begin : g_pad
      assign mcand_arr_s[g]  = 64'd0;
      assign mplier_arr_s[g] = 64'd0;
    end
  end

  // Round-robin search: first asserted req_valid at or after rr, wrapping.
  always_comb begin
    win_found_s  = 1'b0;
    win_idx_s    = 3'd0;
    search_sum_s = 4'd0;
    search_idx_s = 3'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      search_sum_s = {1'b0, rr_q} + 4'(k);
      search_idx_s = (search_sum_s >= NUM_REQ_W) ? 3'(search_sum_s - NUM_REQ_W)
                                                 : search_sum_s[2:0];
      win_idx_s    = (!win_found_s && valid_pad_s[search_idx_s]) ? search_idx_s : win_idx_s;
      win_found_s  = win_found_s | valid_pad_s[search_idx_s];
    end
  end

  assign accept_s = (state_q == ST_IDLE) && win_found_s;
  assign wd_inc_s = wd_q + 16'd1;

  // Handshake outputs decoded from state; req_ready is held low while reset is asserted.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept_s && !reset && (win_idx_s == 3'(i));
      rsp_valid[i] = (state_q == ST_RESP) && (grant_q == 3'(i));
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    grant_d   = grant_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    wd_d      = wd_q;
    prod_d    = prod_q;
    err_d     = err_q;
    m_start_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          grant_d   = win_idx_s;
          mcand_d   = mcand_arr_s[win_idx_s];
          mplier_d  = mplier_arr_s[win_idx_s];
          rr_d      = (win_idx_s == LAST_REQ) ? 3'd0 : win_idx_s + 3'd1;
          m_start_d = 1'b1;
          state_d   = ST_ISSUE;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        wd_d    = 16'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A real completion wins over a watchdog expiry in the same cycle.
        if (m_done) begin
          prod_d  = m_product;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (wd_inc_s == TIMEOUT_W) begin
          wd_d    = wd_inc_s;
          prod_d  = 64'd0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          wd_d    = wd_inc_s;
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_ready_pad_s[grant_q]) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rr_q      <= 3'd0;
      grant_q   <= 3'd0;
      mcand_q   <= 64'd0;
      mplier_q  <= 64'd0;
      wd_q      <= 16'd0;
      prod_q    <= 64'd0;
      err_q     <= 1'b0;
      m_start_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      wd_q      <= wd_d;
      prod_q    <= prod_d;
      err_q     <= err_d;
      m_start_q <= m_start_d;
      busy_q    <= busy_d;
    end
  end

  assign rsp_product = prod_q;
  assign rsp_err     = err_q;
  assign m_start     = m_start_q;
  assign m_mcand     = mcand_q;
  assign m_mplier    = mplier_q;
  assign busy        = busy_q;
  assign grant_id    = grant_q;

endmodule
